// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parameterised parallel-in serial-out shift register with a load/ready
//   handshake, consumer stall (shift_en) and framing strobes.  Consecutive
//   words stream with no idle bit between them.
//
// Parameters
//   WIDTH     : data word width in bits (2..32)
//   MSB_FIRST : 1 -> pin[WIDTH-1] is sent first, 0 -> pin[0] is sent first
//
// Optional build macro
//   PISO_SERIALIZER_PARITY_EN : when defined, an even-parity bit of the
//   captured word follows the data bits (frame length WIDTH+1).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, highest priority
//   load       in   word offer; accepted on an edge where load && ready
//   pin        in   parallel word, sampled only on an accepting edge
//   shift_en   in   consumer takes the current bit when shift_en && dout_valid
//   ready      out  block can accept a word this cycle (combinational)
//   dout       out  current serial bit, 0 when dout_valid=0
//   dout_valid out  dout holds a frame bit
//   last       out  current bit is the final bit of the frame
//   bit_cnt    out  index of the current bit in the frame, 0 when idle
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [WIDTH-1:0]           pin,
    input  logic                       shift_en,
    output logic                       ready,
    output logic                       dout,
    output logic                       dout_valid,
    output logic                       last,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

`ifdef PISO_SERIALIZER_PARITY_EN
    // Even parity: XOR reduction of the word.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    // The parity bit sits at the far end of the register from the output
    // so it leaves after every data bit, whichever bit order is selected.
    function automatic logic [FL-1:0] frame_word(input logic [WIDTH-1:0] w);
        logic [FL-1:0] f;
        if (MSB_FIRST) begin
            f = {w, even_parity(w)};
        end else begin
            f = {even_parity(w), w};
        end
        return f;
    endfunction
`else
    function automatic logic [FL-1:0] frame_word(input logic [WIDTH-1:0] w);
        return w;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [FL-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;

    logic            valid_s;
    logic            last_s;
    logic            out_bit_s;
    logic            ready_s;

    // Output-side decode, derived from flop state only.
    always_comb begin
        valid_s   = (state_q == S_SHIFT);
        last_s    = valid_s && (bit_cnt_q == LAST_IDX);
        out_bit_s = MSB_FIRST ? shreg_q[FL-1] : shreg_q[0];
        // Ready on the last bit lets the next word land with no bubble.
        ready_s   = !reset && ((state_q == S_IDLE) || (last_s && shift_en));
    end

    // Next-state, shift register and bit counter.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shreg_d   = frame_word(pin);
                    bit_cnt_d = {CW{1'b0}};
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (shift_en) begin
                    if (last_s) begin
                        if (load) begin
                            shreg_d   = frame_word(pin);
                            bit_cnt_d = {CW{1'b0}};
                            state_d   = S_SHIFT;
                        end else begin
                            shreg_d   = {FL{1'b0}};
                            bit_cnt_d = {CW{1'b0}};
                            state_d   = S_IDLE;
                        end
                    end else begin
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[FL-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[FL-1:1]};
                        end
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else begin
                    // Stall: everything holds.
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d   = S_IDLE;
                shreg_d   = {FL{1'b0}};
                bit_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= {FL{1'b0}};
            bit_cnt_q <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign ready      = ready_s;
    assign dout_valid = valid_s;
    assign dout       = valid_s & out_bit_s;
    assign last       = last_s;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Two instances (MSB-first and LSB-first, WIDTH=4) driven by shared inputs.
//   Each accepted word pushes its expected bit stream into a per-instance
//   queue; each observed cycle compares the queue head (or idle values).
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [W-1:0]  pin;
    logic          shift_en;

    logic          ready_m, dout_m, dv_m, last_m;
    logic [CW-1:0] cnt_m;
    logic          ready_l, dout_l, dv_l, last_l;
    logic [CW-1:0] cnt_l;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic          d;
        logic          l;
        logic [CW-1:0] c;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] sm;   // transmission order, MSB-first instance
        logic [W-1:0] sl;   // transmission order, LSB-first instance
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .load(load), .pin(pin), .shift_en(shift_en),
        .ready(ready_m), .dout(dout_m), .dout_valid(dv_m), .last(last_m), .bit_cnt(cnt_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load(load), .pin(pin), .shift_en(shift_en),
        .ready(ready_l), .dout(dout_l), .dout_valid(dv_l), .last(last_l), .bit_cnt(cnt_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic dv, input logic d, input logic l,
                             input logic [CW-1:0] c, input logic has, input exp_t e);
        if (has) begin
            chk({tag, "_valid"}, 32'(dv), 32'd1);
            chk({tag, "_dout"},  32'(d),  32'(e.d));
            chk({tag, "_last"},  32'(l),  32'(e.l));
            chk({tag, "_cnt"},   32'(c),  32'(e.c));
        end else begin
            chk({tag, "_valid"}, 32'(dv), 32'd0);
            chk({tag, "_dout"},  32'(d),  32'd0);
            chk({tag, "_last"},  32'(l),  32'd0);
            chk({tag, "_cnt"},   32'(c),  32'd0);
        end
    endtask

    task automatic push_word(input logic [W-1:0] p, input logic [W-1:0] sm, input logic [W-1:0] sl);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.l = (i == 0) && !PAR;
            e.c = CW'(W - 1 - i);
            e.d = sm[i];
            q_m.push_back(e);
            e.d = sl[i];
            q_l.push_back(e);
        end
        if (PAR) begin
            e.d = ^p;
            e.l = 1'b1;
            e.c = CW'(W);
            q_m.push_back(e);
            q_l.push_back(e);
        end
    endtask

    // One clock cycle: drive, check, advance the model across the edge.
    task automatic step(input logic ld, input logic [W-1:0] p, input logic se, input logic rs,
                        input logic [W-1:0] sm, input logic [W-1:0] sl, output logic acc);
        logic rdy;
        exp_t em, el;
        load = ld; pin = p; shift_en = se; reset = rs;
        #1;
        rdy = !rs && ((q_m.size() == 0) || (q_m[0].l && se));
        chk("ready_msb", 32'(ready_m), 32'(rdy));
        chk("ready_lsb", 32'(ready_l), 32'(rdy));
        em = (q_m.size() != 0) ? q_m[0] : '0;
        el = (q_l.size() != 0) ? q_l[0] : '0;
        check_dut("msb", dv_m, dout_m, last_m, cnt_m, q_m.size() != 0, em);
        check_dut("lsb", dv_l, dout_l, last_l, cnt_l, q_l.size() != 0, el);
        acc = 1'b0;
        if (rs) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (se && (q_m.size() != 0)) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (ld && rdy) begin
                push_word(p, sm, sl);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, a);
    endtask

    initial begin
        logic a;
        logic [W-1:0] z;
        z = 4'b0000;
        reset = 1'b1; load = 1'b0; pin = 4'b0000; shift_en = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // 1: reset, single word MSB-first
        step(1'b0, z, 1'b1, 1'b1, z, z, a);
        step(1'b0, z, 1'b1, 1'b1, z, z, a);
        step(1'b1, 4'b0101, 1'b1, 1'b0, 4'b0101, 4'b1010, a);
        idle(7);

        // 2: back-to-back, load held, pin switched on the last bit
        step(1'b1, 4'b1101, 1'b1, 1'b0, 4'b1101, 4'b1011, a);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1101, 1'b1, 1'b0, 4'b1101, 4'b1011, a);
        step(1'b1, 4'b1000, 1'b1, 1'b0, 4'b1000, 4'b0001, a);
        idle(7);

        // 3: stall after the first bit
        step(1'b1, 4'b0110, 1'b1, 1'b0, 4'b0110, 4'b0110, a);
        for (int i = 0; i < 3; i++) step(1'b0, z, 1'b0, 1'b0, z, z, a);
        idle(6);

        // 4: load while busy is ignored
        step(1'b1, 4'b0111, 1'b1, 1'b0, 4'b0111, 4'b1110, a);
        step(1'b0, z, 1'b1, 1'b0, z, z, a);
        step(1'b1, 4'b1111, 1'b1, 1'b0, 4'b1111, 4'b1111, a);
        idle(6);

        // 5: reset mid-frame, then a fresh word
        step(1'b1, 4'b1010, 1'b1, 1'b0, 4'b1010, 4'b0101, a);
        idle(2);
        step(1'b0, z, 1'b1, 1'b1, z, z, a);
        step(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0010, a);
        idle(7);

        // Table: words streamed with load held and random consumer stalls
        tbl[0] = '{4'b0011, 4'b0011, 4'b1100};
        tbl[1] = '{4'b1001, 4'b1001, 4'b1001};
        tbl[2] = '{4'b1110, 4'b1110, 4'b0111};
        tbl[3] = '{4'b0001, 4'b0001, 4'b1000};
        tbl[4] = '{4'b1011, 4'b1011, 4'b1101};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000};
        tbl[6] = '{4'b1111, 4'b1111, 4'b1111};
        tbl[7] = '{4'b0110, 4'b0110, 4'b0110};
        for (int t = 0; t < 8; t++) begin
            a = 1'b0;
            for (int k = 0; k < 40 && !a; k++) begin
                step(1'b1, tbl[t].p, ($urandom_range(0, 3) != 0), 1'b0, tbl[t].sm, tbl[t].sl, a);
            end
            n_cmp++;
            if (!a) begin
                n_err++;
                $display("FAIL accept_timeout: word %0d got no accept expected accept within 40 cycles", t);
            end
        end
        for (int k = 0; k < 20 && q_m.size() != 0; k++) idle(1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
